// File: rtl/calc_pkg.sv
// Shared types and defaults for the calculator command sequencer.
package calc_pkg;

  localparam int unsigned DEFAULT_DATA_W = 16;
  localparam int unsigned DEFAULT_TAG_W  = 4;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_t;

  typedef struct packed {
    logic [DEFAULT_DATA_W-1:0] a;
    logic [DEFAULT_DATA_W-1:0] b;
    op_t                       op;
    logic [DEFAULT_TAG_W-1:0]  tag;
  } cmd_t;

  typedef struct packed {
    logic [DEFAULT_DATA_W-1:0] result;
    logic [DEFAULT_TAG_W-1:0]  tag;
    logic                      dz;
  } rsp_t;

  // Flags a divide whose divisor is zero; the result itself is passed through untouched.
  function automatic logic is_div_zero(input logic [1:0] op, input logic b_zero);
    return (op_t'(op) == OP_DIV) && b_zero;
  endfunction

endpackage

// File: rtl/calc_cmd_sequencer_if.sv
// Command, calculator and response signals of the sequencer, grouped for port use.
interface calc_cmd_sequencer_if
  import calc_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W,
  parameter int unsigned TAG_W  = DEFAULT_TAG_W
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;
  logic [1:0]        cmd_op;
  logic [TAG_W-1:0]  cmd_tag;

  logic [DATA_W-1:0] calc_a;
  logic [DATA_W-1:0] calc_b;
  logic [1:0]        calc_op;
  logic [DATA_W-1:0] calc_result;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_result;
  logic [TAG_W-1:0]  rsp_tag;
  logic              rsp_dz;

  // Environment side: command producer, calculator and response consumer.
  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag, calc_result, rsp_ready,
    input  cmd_ready, calc_a, calc_b, calc_op, rsp_valid, rsp_result, rsp_tag, rsp_dz
  );

  // Sequencer side.
  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag, calc_result, rsp_ready,
    output cmd_ready, calc_a, calc_b, calc_op, rsp_valid, rsp_result, rsp_tag, rsp_dz
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; head reads as zero when empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

  // A push into a full FIFO is only taken when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Pointer and occupancy next state.
  always_comb begin
    wptr_d  = do_push ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = do_pop ? rptr_q + AW'(1) : rptr_q;
    count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Data storage needs no reset; the empty mask hides stale entries.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/calc_cmd_sequencer.sv
// Buffers calculator commands, issues them only against reserved response space and
// returns tagged results in acceptance order.
module calc_cmd_sequencer
  import calc_pkg::*;
#(
  parameter int unsigned DATA_W    = DEFAULT_DATA_W,
  parameter int unsigned TAG_W     = DEFAULT_TAG_W,
  parameter int unsigned CMD_DEPTH = 4,
  parameter int unsigned RSP_DEPTH = 4,
  parameter int unsigned CALC_LAT  = 1
) (
  input  logic                clk,
  input  logic                rst,
  calc_cmd_sequencer_if.slave bus,
  output logic                busy
);
  localparam int unsigned PipeD = CALC_LAT + 1;
  localparam int unsigned CntW  = $clog2(RSP_DEPTH) + 2;
  localparam int unsigned CmdW  = 2 * DATA_W + 2 + TAG_W;
  localparam int unsigned RspW  = DATA_W + TAG_W + 1;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [1:0]        op;
    logic [TAG_W-1:0]  tag;
  } cmd_w_t;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [TAG_W-1:0]  tag;
    logic              dz;
  } rsp_w_t;

  cmd_w_t                   cmd_wdata, cmd_rdata;
  logic                     cmd_push, cmd_full, cmd_empty;
  logic [$clog2(CMD_DEPTH):0] cmd_count;
  rsp_w_t                   rsp_wdata, rsp_rdata;
  logic                     rsp_push, rsp_pop, rsp_full, rsp_empty;
  logic [$clog2(RSP_DEPTH):0] rsp_count;

  logic [DATA_W-1:0] calc_a_q, calc_a_d, calc_b_q, calc_b_d;
  logic [1:0]        calc_op_q, calc_op_d;
  logic [CntW-1:0]   inflight_q, inflight_d, credit_used;
  logic [PipeD-1:0]  pipe_vld_q, pipe_dz_q;
  logic [TAG_W-1:0]  pipe_tag_q [PipeD];
  logic              issue, issue_dz;

  assign cmd_wdata     = '{a: bus.cmd_a, b: bus.cmd_b, op: bus.cmd_op, tag: bus.cmd_tag};
  assign bus.cmd_ready = !cmd_full;
  assign cmd_push      = bus.cmd_valid && !cmd_full;

  sync_fifo #(
    .WIDTH (CmdW),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (cmd_push),
    .wdata_i (cmd_wdata),
    .pop_i   (issue),
    .rdata_o (cmd_rdata),
    .full_o  (cmd_full),
    .empty_o (cmd_empty),
    .count_o (cmd_count)
  );

  // A response pop this cycle frees its slot for this cycle's issue decision.
  assign rsp_pop     = !rsp_empty && bus.rsp_ready;
  assign credit_used = inflight_q + CntW'(rsp_count) - CntW'(rsp_pop);
  assign issue       = !cmd_empty && (credit_used < CntW'(RSP_DEPTH));
  assign issue_dz    = is_div_zero(cmd_rdata.op, cmd_rdata.b == '0);

  // Pipe tail lines up with the calculator result for that issue.
  assign rsp_push  = pipe_vld_q[PipeD-1];
  assign rsp_wdata = '{result: bus.calc_result, tag: pipe_tag_q[PipeD-1], dz: pipe_dz_q[PipeD-1]};

  sync_fifo #(
    .WIDTH (RspW),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (rsp_push),
    .wdata_i (rsp_wdata),
    .pop_i   (rsp_pop),
    .rdata_o (rsp_rdata),
    .full_o  (rsp_full),
    .empty_o (rsp_empty),
    .count_o (rsp_count)
  );

  assign bus.rsp_valid  = !rsp_empty;
  assign bus.rsp_result = rsp_rdata.result;
  assign bus.rsp_tag    = rsp_rdata.tag;
  assign bus.rsp_dz     = rsp_rdata.dz;
  assign bus.calc_a     = calc_a_q;
  assign bus.calc_b     = calc_b_q;
  assign bus.calc_op    = calc_op_q;
  assign busy           = (cmd_count != '0) || (inflight_q != '0) || !rsp_empty;

  // Calculator operands load on issue and hold otherwise; in-flight count tracks the pipe.
  always_comb begin
    calc_a_d   = calc_a_q;
    calc_b_d   = calc_b_q;
    calc_op_d  = calc_op_q;
    inflight_d = inflight_q + CntW'(issue) - CntW'(rsp_push);
    if (issue) begin
      calc_a_d  = cmd_rdata.a;
      calc_b_d  = cmd_rdata.b;
      calc_op_d = cmd_rdata.op;
    end
  end

  // Operand registers, in-flight counter and the result-alignment pipe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      calc_a_q   <= '0;
      calc_b_q   <= '0;
      calc_op_q  <= '0;
      inflight_q <= '0;
      pipe_vld_q <= '0;
      pipe_dz_q  <= '0;
      for (int i = 0; i < PipeD; i++) begin
        pipe_tag_q[i] <= '0;
      end
    end else begin
      calc_a_q      <= calc_a_d;
      calc_b_q      <= calc_b_d;
      calc_op_q     <= calc_op_d;
      inflight_q    <= inflight_d;
      pipe_vld_q    <= {pipe_vld_q[PipeD-2:0], issue};
      pipe_dz_q     <= {pipe_dz_q[PipeD-2:0], issue && issue_dz};
      pipe_tag_q[0] <= cmd_rdata.tag;
      for (int i = 1; i < PipeD; i++) begin
        pipe_tag_q[i] <= pipe_tag_q[i-1];
      end
    end
  end

  // Reserved credit means a landing result always finds a free response slot.
  a_rsp_no_overflow : assert property (@(posedge clk) disable iff (rst) !(rsp_push && rsp_full));

endmodule
